// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter command sequencer.
// Command opcodes, FSM states and the default counter geometry.
package counter_ctrl_pkg;

    localparam int CNT_W_DEF  = 4;
    localparam int STEP_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/counter_ctrl_steps.sv
// Remaining-steps down-counter for the RUN phase of counter_ctrl.
// Loaded on command accept, decremented once per enabled cycle; 'last' flags the final step.
module counter_ctrl_steps #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              dec,
    output logic              last
);

    logic [STEP_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == STEP_W'(1));

endmodule

// File: rtl/counter_ctrl.sv
// Command sequencer driving the load/enable/direction controls of an up/down counter.
// Optional build macro CNT_CTRL_SAT_EN: stop at the counter boundary instead of wrapping.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              cnt_load,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic [CNT_W-1:0]  cnt_din,
    input  logic [CNT_W-1:0]  cnt_q,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              sat
);

    state_e           state_q;
    state_e           state_d;
    op_e              op;
    logic             accept;
    logic             cnt_up_q;
    logic [CNT_W-1:0] din_q;
    logic             boundary;
    logic             block;
    logic             last_step;

    assign op       = op_e'(cmd_op);
    assign accept   = cmd_valid && (state_q == S_IDLE);
    // The next enabled step would cross the top (counting up) or bottom (counting down).
    assign boundary = cnt_up_q ? (cnt_q == {CNT_W{1'b1}}) : (cnt_q == '0);

`ifdef CNT_CTRL_SAT_EN
    assign block = (state_q == S_RUN) && boundary;
`else
    assign block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: every flop is written with <= so all registers update from pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_LOAD:        state_d = S_LOAD;
                        OP_UP, OP_DOWN: state_d = (cmd_steps != '0) ? S_RUN : S_DONE;
                        default:        state_d = S_DONE;
                    endcase
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_RUN:   state_d = (block || last_step) ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        cnt_load  = (state_q == S_LOAD);
        cnt_en    = (state_q == S_RUN) && !block;
        done      = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_up_q <= 1'b0;
            din_q    <= '0;
        end else if (accept) begin
            cnt_up_q <= (op == OP_UP);
            if (op == OP_LOAD) begin
                din_q <= cmd_data;
            end
        end
    end

    assign cnt_up  = cnt_up_q;
    assign cnt_din = din_q;

    // A blocked step reloads zero so leftover steps never leak into the next command.
    counter_ctrl_steps #(
        .STEP_W (STEP_W)
    ) u_steps (
        .clk      (clk),
        .reset    (reset),
        .load     (accept || block),
        .load_val (block ? '0 : cmd_steps),
        .dec      (cnt_en),
        .last     (last_step)
    );

`ifdef CNT_CTRL_SAT_EN
    logic sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= 1'b0;
        end else if (block) begin
            sat_q <= 1'b1;
        end
    end

    assign sat  = (state_q == S_DONE) && sat_q;
    assign wrap = 1'b0;
`else
    logic wrap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= cnt_en && boundary;
        end
    end

    assign wrap = wrap_q;
    assign sat  = 1'b0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: behavioural counter plus an arithmetic model of each command's outcome.
// Honours CNT_CTRL_SAT_EN the same way the design does.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int CNT_W  = 4;
    localparam int STEP_W = 8;
    localparam int OPI_NOP  = int'(OP_NOP);
    localparam int OPI_LOAD = int'(OP_LOAD);
    localparam int OPI_UP   = int'(OP_UP);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [CNT_W-1:0]  cmd_data = '0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_up;
    logic [CNT_W-1:0]  cnt_din;
    logic [CNT_W-1:0]  cnt_q = '0;
    logic              busy;
    logic              done;
    logic              wrap;
    logic              sat;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    counter_ctrl #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .cnt_load  (cnt_load),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .cnt_din   (cnt_din),
        .cnt_q     (cnt_q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // The counter datapath the sequencer drives.
    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_din;
        else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    typedef struct {
        int lat;
        int loads;
        int ens;
        int wraps;
        int sat;
        int fin;
    } exp_t;

    // Outcome of one command from its opcode, operands and the counter value at accept.
    function automatic exp_t model(int op, int data, int steps, int start);
        exp_t e;
        int   cmax = int'(CNT_MAX);
        int   span = cmax + 1;
        int   room;
        e = '{lat: 1, loads: 0, ens: 0, wraps: 0, sat: 0, fin: start};
        if (op == OPI_LOAD) begin
            e.lat = 2; e.loads = 1; e.fin = data;
        end else if (op != OPI_NOP && steps != 0) begin
            room = (op == OPI_UP) ? cmax - start : start;
`ifdef CNT_CTRL_SAT_EN
            if (steps > room) begin
                e.ens = room; e.lat = room + 2; e.sat = 1;
            end else begin
                e.ens = steps; e.lat = steps + 1;
            end
`else
            e.ens   = steps;
            e.lat   = steps + 1;
            e.wraps = (op == OPI_UP) ? (start + steps) / span : (steps + cmax - start) / span;
`endif
            e.fin = (op == OPI_UP) ? (start + e.ens) % span
                                   : (((start - e.ens) % span) + span) % span;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the IDLE cycle after done.
    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] data,
                           input logic [STEP_W-1:0] steps, input bit hold);
        exp_t e;
        int   guard = 0;
        int   cyc = 0;
        int   done_at = 0;
        int   sat_at_done = 0;
        int   loads = 0, ens = 0, wraps = 0;
        int   overlap = 0, hs_bad = 0, up_bad = 0, din_bad = 0, sat_stray = 0;
        e = model(int'(op), int'(data), int'(steps), model_cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = steps;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(cmd_ready), 32'd1);
        while (done_at == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                cmd_op    = 2'($urandom_range(3));
                cmd_data  = CNT_W'($urandom);
                cmd_steps = STEP_W'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if (cnt_load) loads++;
            if (cnt_en) ens++;
            if (wrap) wraps++;
            if (cnt_load && cnt_en) overlap++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) hs_bad++;
            if (cnt_load && cnt_din !== data) din_bad++;
            if (cnt_en && cnt_up !== (op == OP_UP)) up_bad++;
            if (done === 1'b1) begin
                done_at = cyc;
                sat_at_done = sat ? 1 : 0;
            end else if (sat !== 1'b0) begin
                sat_stray++;
            end
        end
        check("done_seen", 32'(done_at != 0), 32'd1);
        check("done_latency", done_at, e.lat);
        check("load_cycles", loads, e.loads);
        check("enable_cycles", ens, e.ens);
        check("wrap_pulses", wraps, e.wraps);
        check("sat_with_done", sat_at_done, e.sat);
        check("sat_stray", sat_stray, 0);
        check("load_en_overlap", overlap, 0);
        check("ready_while_busy", hs_bad, 0);
        check("direction", up_bad, 0);
        check("load_data", din_bad, 0);
        @(negedge clk);
        check("post_ready", 32'(cmd_ready), 32'd1);
        check("post_done", 32'(done), 32'd0);
        check("post_wrap", 32'(wrap), 32'd0);
        check("final_count", 32'(cnt_q), e.fin);
        model_cnt = e.fin;
    endtask

    initial begin
        logic [1:0]        r_op;
        logic [CNT_W-1:0]  r_data;
        logic [STEP_W-1:0] r_steps;
        int                en_seen;
        int                guard;
        int                stray_done;

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({cnt_load, cnt_en, cnt_up, done, wrap, sat, busy}), 32'd0);
        check("reset_din", 32'(cnt_din), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(OP_LOAD, 4'hA, 8'd0, 1'b0);
        run_cmd(OP_LOAD, 4'h3, 8'd0, 1'b0);
        run_cmd(OP_UP,   4'h0, 8'd5, 1'b0);
        run_cmd(OP_LOAD, 4'hE, 8'd0, 1'b0);
        run_cmd(OP_UP,   4'h0, 8'd3, 1'b0);
        run_cmd(OP_LOAD, 4'h1, 8'd0, 1'b0);
        run_cmd(OP_DOWN, 4'h0, 8'd2, 1'b0);
        run_cmd(OP_DOWN, 4'h0, 8'd0, 1'b0);
        run_cmd(OP_NOP,  4'h7, 8'd9, 1'b0);

        // Host keeps cmd_valid high with changing fields while busy.
        run_cmd(OP_LOAD, 4'h2, 8'd0, 1'b0);
        run_cmd(OP_UP,   4'h0, 8'd4, 1'b1);
        run_cmd(OP_LOAD, 4'h5, 8'd0, 1'b0);

        // Reset during the 4th enabled cycle of a 10-step UP aborts it silently.
        run_cmd(OP_LOAD, 4'h0, 8'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_steps = 8'd10;
        en_seen   = 0;
        guard     = 0;
        stray_done = 0;
        while (en_seen < 4 && guard < 30) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            guard++;
            if (cnt_en) en_seen++;
            if (done) stray_done++;
        end
        check("rst_enables_before", en_seen, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_outputs", 32'({cnt_load, cnt_en, cnt_up, done, wrap, sat, busy}), 32'd0);
        check("rst_din", 32'(cnt_din), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        check("rst_no_done", stray_done, 0);
        check("rst_count", 32'(cnt_q), 32'd4);
        model_cnt = 4;
        run_cmd(OP_NOP, 4'h0, 8'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_op    = 2'($urandom_range(3));
            r_data  = CNT_W'($urandom);
            r_steps = ($urandom_range(3) == 0) ? 8'd0 : STEP_W'($urandom_range(20, 1));
            run_cmd(r_op, r_data, r_steps, ($urandom_range(4) == 0));
        end
        run_cmd(OP_NOP, 4'h0, 8'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
